// File: rtl/dram_wr_ctrl_if.sv
// Store-side data-RAM write bus: execute-stage store requests in,
// word-aligned RAM write beats out, plus hazard/misalign status.
// slave modport: the controller; master modport: execute stage / RAM / hazard side.
interface dram_wr_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned NB = XLEN / 8;

    logic            req_valid_i;
    logic            req_ready_o;
    logic [1:0]      req_sel_i;
    logic [XLEN-1:0] req_addr_i;
    logic [XLEN-1:0] req_data_i;

    logic            dram_wr_en_o;
    logic            dram_wr_ready_i;
    logic [XLEN-1:0] dram_wr_addr_o;
    logic [NB-1:0]   dram_wr_byte_en_o;
    logic [XLEN-1:0] dram_wr_data_o;

    logic            busy_o;
    logic            misalign_err_o;
    logic [XLEN-1:0] misalign_addr_o;

    modport slave (
        input  req_valid_i, req_sel_i, req_addr_i, req_data_i, dram_wr_ready_i,
        output req_ready_o, dram_wr_en_o, dram_wr_addr_o, dram_wr_byte_en_o,
               dram_wr_data_o, busy_o, misalign_err_o, misalign_addr_o
    );

    modport master (
        output req_valid_i, req_sel_i, req_addr_i, req_data_i, dram_wr_ready_i,
        input  req_ready_o, dram_wr_en_o, dram_wr_addr_o, dram_wr_byte_en_o,
               dram_wr_data_o, busy_o, misalign_err_o, misalign_addr_o
    );
endinterface

// File: rtl/dram_wr_ctrl.sv
// Store-side data-RAM controller: buffers store requests in order and emits
// word-aligned, lane-shifted write beats with byte enables.
// Optional feature macro: DRAM_WR_MISALIGN_EN
//   defined   -> misaligned stores are split into one or two beats
//   undefined -> misaligned stores are dropped and flagged on misalign_err_o
module dram_wr_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    dram_wr_ctrl_if.slave  bus
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OB = $clog2(NB);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {S_FIRST, S_SECOND} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;

    logic [XLEN-1:0] buf_addr_q [DEPTH];
    logic [XLEN-1:0] buf_data_q [DEPTH];
    logic [1:0]      buf_sel_q  [DEPTH];

    logic            full_c;
    logic            accept_c;
    logic            push_c;
    logic            pop_c;

    logic [XLEN-1:0] head_addr_c;
    logic [XLEN-1:0] head_data_c;
    logic [1:0]      head_sel_c;
    logic [OB-1:0]   head_off_c;
    logic [2*NB-1:0] base_mask_c;
    logic [2*NB-1:0] mask_c;
    logic [2*XLEN-1:0] wide_c;
    logic [XLEN-1:0] beat0_addr_c;

    logic            en_c;
    logic [XLEN-1:0] addr_c;
    logic [NB-1:0]   be_c;
    logic [XLEN-1:0] data_c;

    // Input handshake: ready depends only on occupancy, never on valid
    assign full_c   = (count_q == CW'(DEPTH));
    assign accept_c = bus.req_valid_i & ~full_c;

`ifdef DRAM_WR_MISALIGN_EN
    assign push_c = accept_c & (bus.req_sel_i != 2'b00);

    assign bus.misalign_err_o  = 1'b0;
    assign bus.misalign_addr_o = '0;
`else
    logic            req_misalign_c;
    logic            misalign_err_q, misalign_err_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

    // A store is misaligned when its address is not a multiple of its size
    always_comb begin
        req_misalign_c = 1'b0;
        case (bus.req_sel_i)
            2'b10:   req_misalign_c = bus.req_addr_i[0];
            2'b11:   req_misalign_c = |bus.req_addr_i[OB-1:0];
            default: req_misalign_c = 1'b0;
        endcase
    end

    assign push_c = accept_c & (bus.req_sel_i != 2'b00) & ~req_misalign_c;

    // Misalign pulse for the cycle after acceptance; address sticks until the next one
    always_comb begin
        misalign_err_d  = accept_c & (bus.req_sel_i != 2'b00) & req_misalign_c;
        misalign_addr_d = misalign_err_d ? bus.req_addr_i : misalign_addr_q;
    end

    // Misalign status registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            misalign_err_q  <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_err_q  <= misalign_err_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign bus.misalign_err_o  = misalign_err_q;
    assign bus.misalign_addr_o = misalign_addr_q;
`endif

    // Head-entry beat math: byte mask and data shifted into a double-word window
    always_comb begin
        head_addr_c = buf_addr_q[rptr_q];
        head_data_c = buf_data_q[rptr_q];
        head_sel_c  = buf_sel_q[rptr_q];
        head_off_c  = head_addr_c[OB-1:0];
        base_mask_c = '0;
        case (head_sel_c)
            2'b01:   base_mask_c = (2*NB)'(1);
            2'b10:   base_mask_c = (2*NB)'(3);
            2'b11:   base_mask_c = {{NB{1'b0}}, {NB{1'b1}}};
            default: base_mask_c = '0;
        endcase
        mask_c       = base_mask_c << head_off_c;
        wide_c       = {{XLEN{1'b0}}, head_data_c} << {head_off_c, 3'b000};
        beat0_addr_c = head_addr_c & ~XLEN'(NB - 1);
    end

    // Output FSM: beat selection and pop decision
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        en_c    = 1'b0;
        addr_c  = '0;
        be_c    = '0;
        data_c  = '0;
        if (count_q != '0) begin
            en_c = 1'b1;
            case (state_q)
                S_FIRST: begin
                    addr_c = beat0_addr_c;
                    be_c   = mask_c[NB-1:0];
                    data_c = wide_c[XLEN-1:0];
                    if (bus.dram_wr_ready_i) begin
                        if (|mask_c[2*NB-1:NB]) begin
                            state_d = S_SECOND;
                        end else begin
                            pop_c = 1'b1;
                        end
                    end
                end
                S_SECOND: begin
                    addr_c = beat0_addr_c + XLEN'(NB);
                    be_c   = mask_c[2*NB-1:NB];
                    data_c = wide_c[2*XLEN-1:XLEN];
                    if (bus.dram_wr_ready_i) begin
                        pop_c   = 1'b1;
                        state_d = S_FIRST;
                    end
                end
            endcase
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth
    always_comb begin
        count_d = count_q + CW'(push_c) - CW'(pop_c);
        wptr_d  = push_c ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop_c  ? rptr_q + PW'(1) : rptr_q;
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_FIRST;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Store buffer storage
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_addr_q[i] <= '0;
                buf_data_q[i] <= '0;
                buf_sel_q[i]  <= '0;
            end
        end else if (push_c) begin
            buf_addr_q[wptr_q] <= bus.req_addr_i;
            buf_data_q[wptr_q] <= bus.req_data_i;
            buf_sel_q[wptr_q]  <= bus.req_sel_i;
        end
    end

    assign bus.req_ready_o       = ~full_c;
    assign bus.busy_o            = (count_q != '0);
    assign bus.dram_wr_en_o      = en_c;
    assign bus.dram_wr_addr_o    = addr_c;
    assign bus.dram_wr_byte_en_o = be_c;
    assign bus.dram_wr_data_o    = data_c;

endmodule

// File: tb/tb_dram_wr_ctrl.sv
// Bench for dram_wr_ctrl: directed cases plus randomized traffic against
// a queue-based store model. Honors DRAM_WR_MISALIGN_EN like the design.
module tb_dram_wr_ctrl;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;

    dram_wr_ctrl_if #(.XLEN(32)) bus ();

    dram_wr_ctrl #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  sel;
    } store_t;

    store_t      mq[$];
    int          m_beat;
    logic        m_err;
    logic [31:0] m_err_addr;

    int n_chk;
    int n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] sel);
        return (sel == 2'b01) ? 1 : (sel == 2'b10) ? 2 : 4;
    endfunction

    function automatic bit crosses(input store_t e);
        return (int'(e.addr % 4) + size_of(e.sel)) > 4;
    endfunction

    // Expected beat idx of a store from byte-level arithmetic
    task automatic exp_beat(input store_t e, input int idx,
                            output logic [31:0] a, output logic [3:0] be, output logic [31:0] d);
        int              n;
        int              off;
        longint unsigned m;
        longint unsigned w;
        n   = size_of(e.sel);
        off = int'(e.addr % 4);
        m   = ((64'd1 << n) - 64'd1) << off;
        w   = {32'd0, e.data} << (8 * off);
        a   = 32'(e.addr - 32'(off) + 32'(4 * idx));
        be  = 4'(m >> (4 * idx));
        d   = 32'(w >> (32 * idx));
    endtask

    // Advance the model by one clock edge with the given inputs
    task automatic model_step(input logic v, input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] d, input logic r);
        bit     acc;
        bit     mis;
        store_t e;
        acc   = v && (mq.size() < DEPTH);
        mis   = (s != 2'b00) && ((a % 32'(size_of(s))) != 0);
        m_err = 1'b0;
        if (mq.size() != 0 && r) begin
            if (m_beat == 0 && crosses(mq[0])) begin
                m_beat = 1;
            end else begin
                void'(mq.pop_front());
                m_beat = 0;
            end
        end
        if (acc && s != 2'b00) begin
`ifdef DRAM_WR_MISALIGN_EN
            e.addr = a; e.data = d; e.sel = s;
            mq.push_back(e);
`else
            if (mis) begin
                m_err      = 1'b1;
                m_err_addr = a;
            end else begin
                e.addr = a; e.data = d; e.sel = s;
                mq.push_back(e);
            end
`endif
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ea;
        logic [3:0]  eb;
        logic [31:0] ed;
        check("req_ready", 64'(bus.req_ready_o), 64'(mq.size() < DEPTH));
        check("busy", 64'(bus.busy_o), 64'(mq.size() != 0));
        check("wr_en", 64'(bus.dram_wr_en_o), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            exp_beat(mq[0], m_beat, ea, eb, ed);
        end else begin
            ea = '0; eb = '0; ed = '0;
        end
        check("wr_addr", 64'(bus.dram_wr_addr_o), 64'(ea));
        check("wr_be", 64'(bus.dram_wr_byte_en_o), 64'(eb));
        check("wr_data", 64'(bus.dram_wr_data_o), 64'(ed));
`ifdef DRAM_WR_MISALIGN_EN
        check("mis_err", 64'(bus.misalign_err_o), 64'd0);
        check("mis_addr", 64'(bus.misalign_addr_o), 64'd0);
`else
        check("mis_err", 64'(bus.misalign_err_o), 64'(m_err));
        check("mis_addr", 64'(bus.misalign_addr_o), 64'(m_err_addr));
`endif
    endtask

    // One clock: drive at negedge, update model, sample at next negedge
    task automatic cycle(input logic v, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, input logic r);
        bus.req_valid_i     = v;
        bus.req_sel_i       = s;
        bus.req_addr_i      = a;
        bus.req_data_i      = d;
        bus.dram_wr_ready_i = r;
        model_step(v, s, a, d, r);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic model_reset();
        mq.delete();
        m_beat     = 0;
        m_err      = 1'b0;
        m_err_addr = '0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        model_reset();
        rst_n               = 1'b0;
        bus.req_valid_i     = 1'b0;
        bus.req_sel_i       = 2'b00;
        bus.req_addr_i      = '0;
        bus.req_data_i      = '0;
        bus.dram_wr_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.req_ready_o), 64'd1);
        check("rst_en", 64'(bus.dram_wr_en_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_mis_err", 64'(bus.misalign_err_o), 64'd0);
        check("rst_mis_addr", 64'(bus.misalign_addr_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned word store
        cycle(1'b1, 2'b11, 32'h100, 32'hDEADBEEF, 1'b1);
        check("sw_en", 64'(bus.dram_wr_en_o), 64'd1);
        check("sw_addr", 64'(bus.dram_wr_addr_o), 64'h100);
        check("sw_be", 64'(bus.dram_wr_byte_en_o), 64'hF);
        check("sw_data", 64'(bus.dram_wr_data_o), 64'hDEADBEEF);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        check("sw_busy_after", 64'(bus.busy_o), 64'd0);

        // Byte then half, lane-shifted
        cycle(1'b1, 2'b01, 32'h203, 32'h000000A5, 1'b1);
        check("sb_addr", 64'(bus.dram_wr_addr_o), 64'h200);
        check("sb_be", 64'(bus.dram_wr_byte_en_o), 64'h8);
        check("sb_data", 64'(bus.dram_wr_data_o), 64'hA5000000);
        cycle(1'b1, 2'b10, 32'h202, 32'h00001234, 1'b1);
        check("sh_be", 64'(bus.dram_wr_byte_en_o), 64'hC);
        check("sh_data", 64'(bus.dram_wr_data_o), 64'h12340000);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

        // Backpressure: third push refused, beat held stable
        cycle(1'b1, 2'b11, 32'h400, 32'h11111111, 1'b0);
        cycle(1'b1, 2'b11, 32'h404, 32'h22222222, 1'b0);
        check("full_ready", 64'(bus.req_ready_o), 64'd0);
        cycle(1'b1, 2'b11, 32'h408, 32'h33333333, 1'b0);
        check("hold_addr", 64'(bus.dram_wr_addr_o), 64'h400);
        repeat (3) cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

        // Simultaneous push and pop at count 1
        cycle(1'b1, 2'b11, 32'h500, 32'hAAAA0001, 1'b0);
        cycle(1'b1, 2'b11, 32'h504, 32'hAAAA0002, 1'b1);
        check("pp_busy", 64'(bus.busy_o), 64'd1);
        check("pp_head", 64'(bus.dram_wr_addr_o), 64'h504);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

`ifdef DRAM_WR_MISALIGN_EN
        // Word-crossing word store splits into two beats
        cycle(1'b1, 2'b11, 32'h1FE, 32'hAABBCCDD, 1'b0);
        check("x0_addr", 64'(bus.dram_wr_addr_o), 64'h1FC);
        check("x0_be", 64'(bus.dram_wr_byte_en_o), 64'hC);
        check("x0_data", 64'(bus.dram_wr_data_o), 64'hCCDD0000);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        check("x1_addr", 64'(bus.dram_wr_addr_o), 64'h200);
        check("x1_be", 64'(bus.dram_wr_byte_en_o), 64'h3);
        check("x1_data", 64'(bus.dram_wr_data_o), 64'h0000AABB);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
`else
        // Misaligned half is dropped and flagged for one cycle
        cycle(1'b1, 2'b10, 32'h301, 32'h0000BEEF, 1'b1);
        check("mis_pulse", 64'(bus.misalign_err_o), 64'd1);
        check("mis_addr_v", 64'(bus.misalign_addr_o), 64'h301);
        check("mis_nowrite", 64'(bus.dram_wr_en_o), 64'd0);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        check("mis_pulse_end", 64'(bus.misalign_err_o), 64'd0);
        check("mis_addr_hold", 64'(bus.misalign_addr_o), 64'h301);
`endif

        // Reset in the middle of a drain clears everything at once
        cycle(1'b1, 2'b11, 32'h600, 32'h12345678, 1'b0);
        cycle(1'b1, 2'b11, 32'h604, 32'h9ABCDEF0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mrst_en", 64'(bus.dram_wr_en_o), 64'd0);
        check("mrst_busy", 64'(bus.busy_o), 64'd0);
        check("mrst_ready", 64'(bus.req_ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

        // Randomized traffic, biased toward word edges and wrap-around addresses
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), ra, $urandom,
                  1'($urandom_range(0, 9) < 6));
        end
        repeat (8) cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
